reg_rename_file: RTL and testbench

REG_RENAME_FILE -- requirements
Module: reg_rename_file

---
 rtl/reg_rename_file.sv | 119 +++++++++++
 tb/tb_reg_rename_file.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/reg_rename_file.sv
// Architectural register file with rename tags: each register holds a value
// plus the ROB tag of its pending producer, with commit bypass on reads.
module reg_rename_file #(
   parameter int XLEN  = 32,
   parameter int TAG_W = 4,
   parameter int NREG  = 32,
   parameter int IDX_W = $clog2(NREG)
) (
   input  logic             clk_in,
   input  logic             rst_n_in,
   input  logic             rdy_in,
   input  logic             rn_en,
   input  logic [IDX_W-1:0] rn_rd,
   input  logic [TAG_W-1:0] rn_tag,
   input  logic             cm_en,
   input  logic [IDX_W-1:0] cm_rd,
   input  logic [TAG_W-1:0] cm_tag,
   input  logic [XLEN-1:0]  cm_data,
   input  logic             flush,
   input  logic [IDX_W-1:0] rs1,
   input  logic [IDX_W-1:0] rs2,
   output logic [XLEN-1:0]  vj,
   output logic [XLEN-1:0]  vk,
   output logic [TAG_W-1:0] qj,
   output logic [TAG_W-1:0] qk,
   output logic [IDX_W:0]   busy_cnt
);

   logic [XLEN-1:0]  value_reg [NREG];
   logic [TAG_W-1:0] tag_reg   [NREG];
   logic [XLEN-1:0]  value_next [NREG];
   logic [TAG_W-1:0] tag_next   [NREG];
   logic [IDX_W:0]   busy_reg;
   logic [IDX_W:0]   busy_next;

   logic commit_wr;
   logic commit_match;
   logic rename_wr;

   assign commit_wr    = rdy_in && cm_en && (cm_rd != '0);
   assign commit_match = (tag_reg[cm_rd] == cm_tag);
   assign rename_wr    = rdy_in && rn_en && (rn_rd != '0) && (rn_tag != '0) && !flush;

   // Next-state: commit first, then flush or rename overrides the tag.
   always_comb begin
      for (int i = 0; i < NREG; i++) begin
         value_next[i] = value_reg[i];
         tag_next[i]   = tag_reg[i];
      end
      if (commit_wr) begin
         value_next[cm_rd] = cm_data;
         if (commit_match)
            tag_next[cm_rd] = '0;
      end
      if (rdy_in && flush) begin
         for (int i = 0; i < NREG; i++)
            tag_next[i] = '0;
      end
      if (rename_wr)
         tag_next[rn_rd] = rn_tag;
   end

   always_comb begin
      busy_next = '0;
      for (int i = 1; i < NREG; i++)
         busy_next = busy_next + {{IDX_W{1'b0}}, (tag_next[i] != '0)};
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         for (int i = 0; i < NREG; i++) begin
            value_reg[i] <= '0;
            tag_reg[i]   <= '0;
         end
         busy_reg <= '0;
      end else if (rdy_in) begin
         for (int i = 1; i < NREG; i++) begin
            value_reg[i] <= value_next[i];
            tag_reg[i]   <= tag_next[i];
         end
         value_reg[0] <= '0;
         tag_reg[0]   <= '0;
         busy_reg     <= busy_next;
      end
   end

   assign busy_cnt = busy_reg;

   // Bypass only when the committing entry is the current producer of the source.
   logic bypass_ok;
   assign bypass_ok = rdy_in && cm_en && (cm_rd != '0) && (cm_tag != '0) && commit_match;

   logic [IDX_W-1:0] src_idx [2];
   logic [XLEN-1:0]  src_v   [2];
   logic [TAG_W-1:0] src_q   [2];

   assign src_idx[0] = rs1;
   assign src_idx[1] = rs2;

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_read
         always_comb begin
            src_q[gi] = tag_reg[src_idx[gi]];
            src_v[gi] = (tag_reg[src_idx[gi]] == '0) ? value_reg[src_idx[gi]] : '0;
            if (bypass_ok && (src_idx[gi] == cm_rd)) begin
               src_q[gi] = '0;
               src_v[gi] = cm_data;
            end
         end
      end
   endgenerate

   assign vj = src_v[0];
   assign qj = src_q[0];
   assign vk = src_v[1];
   assign qk = src_q[1];

endmodule

// File: tb/tb_reg_rename_file.sv
// Directed bench for reg_rename_file: stimulus pushes expected reads into a
// scoreboard queue; a negedge monitor pops and compares.
module tb_reg_rename_file;

   localparam int XLEN  = 32;
   localparam int TAG_W = 4;
   localparam int NREG  = 32;
   localparam int IDX_W = 5;

   logic             clk_in = 1'b0;
   logic             rst_n_in;
   logic             rdy_in;
   logic             rn_en;
   logic [IDX_W-1:0] rn_rd;
   logic [TAG_W-1:0] rn_tag;
   logic             cm_en;
   logic [IDX_W-1:0] cm_rd;
   logic [TAG_W-1:0] cm_tag;
   logic [XLEN-1:0]  cm_data;
   logic             flush;
   logic [IDX_W-1:0] rs1;
   logic [IDX_W-1:0] rs2;
   logic [XLEN-1:0]  vj;
   logic [XLEN-1:0]  vk;
   logic [TAG_W-1:0] qj;
   logic [TAG_W-1:0] qk;
   logic [IDX_W:0]   busy_cnt;

   reg_rename_file #(.XLEN(XLEN), .TAG_W(TAG_W), .NREG(NREG)) dut (
      .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in),
      .rn_en(rn_en), .rn_rd(rn_rd), .rn_tag(rn_tag),
      .cm_en(cm_en), .cm_rd(cm_rd), .cm_tag(cm_tag), .cm_data(cm_data),
      .flush(flush), .rs1(rs1), .rs2(rs2),
      .vj(vj), .vk(vk), .qj(qj), .qk(qk), .busy_cnt(busy_cnt)
   );

   always #5 clk_in = ~clk_in;

   typedef enum int {K_VJ, K_QJ, K_VK, K_QK, K_BUSY} kind_t;
   typedef struct {
      string name;
      kind_t kind;
      logic [31:0] exp;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   fails  = 0;

   task automatic push(input string name, input kind_t kind, input logic [31:0] exp);
      exp_t e;
      e.name = name;
      e.kind = kind;
      e.exp  = exp;
      sb.push_back(e);
   endtask

   task automatic expect_j(input string name, input logic [31:0] q, input logic [31:0] v);
      push({name, "_qj"}, K_QJ, q);
      push({name, "_vj"}, K_VJ, v);
   endtask

   task automatic expect_k(input string name, input logic [31:0] q, input logic [31:0] v);
      push({name, "_qk"}, K_QK, q);
      push({name, "_vk"}, K_VK, v);
   endtask

   // Monitor: compare everything queued for this cycle at the falling edge.
   always @(negedge clk_in) begin
      while (sb.size() > 0) begin
         exp_t e;
         logic [31:0] act;
         e = sb.pop_front();
         case (e.kind)
            K_VJ:    act = vj;
            K_QJ:    act = {28'd0, qj};
            K_VK:    act = vk;
            K_QK:    act = {28'd0, qk};
            default: act = {26'd0, busy_cnt};
         endcase
         checks++;
         if (act !== e.exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", e.name, act, e.exp);
         end else begin
            $display("ok   %s = 0x%0h", e.name, act);
         end
      end
   end

   task automatic idle();
      rdy_in  = 1'b1;
      rn_en   = 1'b0; rn_rd = '0; rn_tag = '0;
      cm_en   = 1'b0; cm_rd = '0; cm_tag = '0; cm_data = '0;
      flush   = 1'b0;
      rs1     = '0;   rs2 = '0;
   endtask

   task automatic step();
      @(posedge clk_in);
      #1;
      idle();
   endtask

   initial begin
      idle();
      rst_n_in = 1'b0;
      // Reset held: activity must be ignored
      rn_en = 1'b1; rn_rd = 5'd2; rn_tag = 4'd1;
      rs1 = 5'd5; rs2 = 5'd2;
      #1;
      expect_j("reset_rs5", 0, 0);
      expect_k("reset_rs2", 0, 0);
      push("reset_busy", K_BUSY, 0);
      @(posedge clk_in);
      #1;
      push("reset_busy2", K_BUSY, 0);
      expect_k("reset_rs2b", 0, 0);
      step(); rst_n_in = 1'b1;
      rs1 = 5'd2;
      expect_j("post_reset_x2", 0, 0);
      push("post_reset_busy", K_BUSY, 0);

      step(); rn_en = 1; rn_rd = 5; rn_tag = 3; rs1 = 5;
      expect_j("rename5_same_cycle", 0, 0);
      step(); rs1 = 5;
      expect_j("x5_pending", 3, 0);
      push("busy_after_rn5", K_BUSY, 1);
      step(); cm_en = 1; cm_rd = 5; cm_tag = 3; cm_data = 32'hDEADBEEF; rs1 = 5;
      expect_j("x5_bypass", 0, 32'hDEADBEEF);
      push("busy_during_cm5", K_BUSY, 1);
      step(); rs1 = 5;
      expect_j("x5_committed", 0, 32'hDEADBEEF);
      push("busy_after_cm5", K_BUSY, 0);

      step(); rn_en = 1; rn_rd = 7; rn_tag = 2;
      step(); rn_en = 1; rn_rd = 7; rn_tag = 6; rs1 = 7;
      expect_j("x7_tag2", 2, 0);
      step(); cm_en = 1; cm_rd = 7; cm_tag = 2; cm_data = 32'h11; rs1 = 7;
      expect_j("x7_stale_commit_nobypass", 6, 0);
      step(); rs1 = 7; rs2 = 7;
      expect_j("x7_tag6_kept", 6, 0);
      push("busy_x7", K_BUSY, 1);

      step(); rn_en = 1; rn_rd = 9; rn_tag = 1;
      step(); rn_en = 1; rn_rd = 9; rn_tag = 4;
      cm_en = 1; cm_rd = 9; cm_tag = 1; cm_data = 32'h55; rs1 = 9;
      expect_j("x9_bypass_with_rename", 0, 32'h55);
      push("busy_x7_x9", K_BUSY, 2);
      step(); rs1 = 9;
      expect_j("x9_rename_wins_tag", 4, 0);
      push("busy_after_x9", K_BUSY, 2);

      step(); rn_en = 1; rn_rd = 3; rn_tag = 7;
      step(); rn_en = 1; rn_rd = 4; rn_tag = 8; rs1 = 3;
      expect_j("x3_tag7", 7, 0);
      push("busy_three", K_BUSY, 3);
      step(); flush = 1; rn_en = 1; rn_rd = 8; rn_tag = 5;
      cm_en = 1; cm_rd = 10; cm_tag = 9; cm_data = 32'hAA;
      rs1 = 4; rs2 = 3;
      expect_j("x4_before_flush", 8, 0);
      expect_k("x3_before_flush", 7, 0);
      push("busy_four", K_BUSY, 4);
      step(); rs1 = 7; rs2 = 9;
      expect_j("x7_after_flush", 0, 32'h11);
      expect_k("x9_after_flush", 0, 32'h55);
      push("busy_after_flush", K_BUSY, 0);
      step(); rs1 = 8; rs2 = 10;
      expect_j("x8_rename_dropped", 0, 0);
      expect_k("x10_commit_in_flush", 0, 32'hAA);

      step(); rn_en = 1; rn_rd = 3; rn_tag = 2;
      step(); rdy_in = 0; rn_en = 1; rn_rd = 1; rn_tag = 2;
      cm_en = 1; cm_rd = 3; cm_tag = 2; cm_data = 32'h77; flush = 1;
      rs1 = 3; rs2 = 1;
      expect_j("x3_frozen_nobypass", 2, 0);
      expect_k("x1_frozen", 0, 0);
      push("busy_frozen", K_BUSY, 1);
      step(); rs1 = 3; rs2 = 1;
      expect_j("x3_still_pending", 2, 0);
      expect_k("x1_no_rename", 0, 0);
      push("busy_unchanged", K_BUSY, 1);

      step(); rn_en = 1; rn_rd = 0; rn_tag = 7; cm_en = 1; cm_rd = 0; cm_data = 32'h99;
      step(); rs1 = 0; rn_en = 1; rn_rd = 12; rn_tag = 0;
      expect_j("x0_hardwired", 0, 0);
      push("busy_x0_ignored", K_BUSY, 1);
      step(); rs2 = 12;
      expect_k("x12_tag0_ignored", 0, 0);
      push("busy_tag0_ignored", K_BUSY, 1);

      // Asynchronous reset mid-operation
      step(); rn_en = 1; rn_rd = 6; rn_tag = 3; rs1 = 5; rs2 = 3;
      rst_n_in = 1'b0;
      expect_j("x5_async_reset", 0, 0);
      expect_k("x3_async_reset", 0, 0);
      push("busy_async_reset", K_BUSY, 0);
      step(); rst_n_in = 1'b1; rs1 = 6;
      expect_j("x6_rename_discarded", 0, 0);

      repeat (3) @(posedge clk_in);
      if (sb.size() != 0) begin
         checks++;
         fails++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
